vga_pixel_fifo: RTL
===================

Name: vga_pixel_fifo

Overview:
- Elastic pixel buffer directly upstream of the 800x600 VGA timing/colour-output stage.
- Accepts 12-bit RGB444 pixels from a producer over a valid/ready handshake and stores each with a start-of-frame tag.
- Hands one pixel per visible-pixel request from the timing stage, aligning producer frames to display frames.
- Reports underflow and frame-misalignment errors; dimension-agnostic (frame size is set by the timing stage).

Parameters:
- AW, 10, address width; FIFO depth = 2**AW entries.
- PIX_W, 12, pixel width (R[11:8] G[7:4] B[3:0]).

Ports:
- clk  in  1  pixel clock (vgaclk domain, 40 MHz).
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  producer pixel valid.
- in_ready  out  1  FIFO can accept; combinational, equals ~full.
- in_data  in  PIX_W  producer pixel.
- in_sof  in  1  marks first pixel of a producer frame.
- frame_start  in  1  one-cycle pulse from timing stage, at least 1 cycle before the first pix_req of a display frame.
- pix_req  in  1  timing stage consumes one pixel this cycle (visible region only).
- pix_data  out  PIX_W  registered pixel, valid 1 cycle after pix_req.
- pix_valid  out  1  registered; 1 when pix_data came from the FIFO.
- level  out  AW+1  current occupancy, 0..2**AW.
- underflow  out  1  sticky: pix_req in RUN while empty.
- sof_err  out  1  sticky: frame misalignment detected.
- clear_err  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async): pointers, level = 0; state = HUNT; pix_data = 0; pix_valid = 0; underflow = 0; sof_err = 0; first_pix = 0.
- Storage: 2**AW x (PIX_W+1) entries `{sof, data}`. Write occurs when in_valid & in_ready, in every state.
- No write-to-read fall-through: a word written in cycle N is first visible at the head in cycle N+1.
- Level arithmetic:
  - Simultaneous push and pop leaves level unchanged.
  - full = (level == 2**AW).
  - empty = (level == 0).
  - Pointers wrap modulo 2**AW.
- HUNT: each cycle, if !empty and head.sof = 0, pop and discard the head. If !empty and head.sof = 1, go to ARMED without popping.
- ARMED: holds. On frame_start, go to RUN and set first_pix = 1.
- RUN:
  - pix_req and !empty and (head.sof = 0 or first_pix): pop, pix_data <= head.data, pix_valid <= 1, first_pix <= 0.
  - pix_req and empty: pix_data <= 0, pix_valid <= 0, underflow <= 1; stay in RUN.
  - pix_req and head.sof = 1 and !first_pix (producer frame too short): no pop, output black, sof_err <= 1, go to ARMED.
  - frame_start while (empty or head.sof = 0), i.e. producer frame too long or late: sof_err <= 1, go to HUNT.
  - frame_start while head.sof = 1: first_pix <= 1, stay in RUN.
- Outside RUN, pix_req yields pix_data = 0 and pix_valid = 0; underflow is not set.
- Registers pix_data and pix_valid hold their previous values when pix_req = 0.
- Precedence: frame_start is evaluated before pix_req; a same-cycle pix_req is served as black.
- clear_err has lower priority than a same-cycle error set: the flag ends set.
- Reset mid-frame discards all contents. The producer must resend from an SOF word.

Test Plan:
- Reset, then idle -> in_ready = 1, level = 0, pix_data = 0, pix_valid = 0, state HUNT, flags 0.
- Write 0x001 (sof = 0), 0x002 (sof = 0), 0xABC (sof = 1), 0x123; frame_start; pix_req x2 -> first two words discarded in HUNT; pix_data = 0xABC then 0x123, each with pix_valid = 1 one cycle after its req; level = 0.
- Fill 1024 words with pix_req = 0 -> in_ready = 0 at level 1024; an in_valid word offered while full is not stored. Then pix_req and in_valid together each cycle -> level stays 1023, data order is preserved across the pointer wrap.
- In RUN with empty FIFO, pix_req -> pix_data = 0, pix_valid = 0, underflow = 1. clear_err -> underflow = 0.
- Producer frame of 3 pixels, display requests 4 -> 4th req returns black, sof_err = 1, state ARMED. The next frame_start restarts aligned, and the next pix_req returns the new SOF pixel.
- Producer frame of 5 pixels, display consumes 4, then frame_start -> sof_err = 1, 5th pixel discarded in HUNT, next SOF served after the following frame_start.

Source files
------------

// File: rtl/vga_pixel_fifo.sv
// Elastic RGB444 pixel buffer feeding the VGA timing stage.
// Stores pixels tagged with start-of-frame and aligns producer frames to display frames.
module vga_pixel_fifo #(
  parameter int unsigned AW    = 10,
  parameter int unsigned PIX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_sof,
  input  logic             frame_start,
  input  logic             pix_req,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_valid,
  output logic [AW:0]      level,
  output logic             underflow,
  output logic             sof_err,
  input  logic             clear_err
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] FullLevel = (AW + 1)'(Depth);

  typedef enum logic [1:0] {StHunt, StArmed, StRun} state_e;

  state_e           state;
  logic [PIX_W:0]   mem [Depth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             first_pix;
  logic             full, empty, push, pop;
  logic             head_sof;
  logic [PIX_W-1:0] head_data;

  assign full     = (level == FullLevel);
  assign empty    = (level == '0);
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign {head_sof, head_data} = mem[rd_ptr];

  // A frame_start in RUN takes the cycle, so a coincident pix_req never pops.
  always_comb begin
    pop = 1'b0;
    case (state)
      StHunt:  pop = !empty && !head_sof;
      StRun:   pop = !frame_start && pix_req && !empty && (!head_sof || first_pix);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_sof, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StHunt;
      first_pix <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      underflow <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      // Clear first so a same-cycle error set below wins.
      if (clear_err) begin
        underflow <= 1'b0;
        sof_err   <= 1'b0;
      end
      // Every request is answered black unless a pixel is actually served.
      if (pix_req) begin
        pix_data  <= '0;
        pix_valid <= 1'b0;
      end
      case (state)
        StHunt: begin
          if (!empty && head_sof) state <= StArmed;
        end
        StArmed: begin
          if (frame_start) begin
            state     <= StRun;
            first_pix <= 1'b1;
          end
        end
        StRun: begin
          if (frame_start) begin
            if (empty || !head_sof) begin
              sof_err <= 1'b1;
              state   <= StHunt;
            end else begin
              first_pix <= 1'b1;
            end
          end else if (pix_req) begin
            if (empty) begin
              underflow <= 1'b1;
            end else if (!head_sof || first_pix) begin
              pix_data  <= head_data;
              pix_valid <= 1'b1;
              first_pix <= 1'b0;
            end else begin
              sof_err <= 1'b1;
              state   <= StArmed;
            end
          end
        end
        default: state <= StHunt;
      endcase
    end
  end

endmodule
